// File: rtl/addroundkey_sched_if.sv
// rtl/addroundkey_sched_if.sv - block/key handshake bundle for addroundkey_sched
//
// Purpose: groups the key-load, block-input and result signals of the
//          AddRoundKey stage so producer and consumer share one port.
// Signals (W = WORD*NB state width):
//   i_key_load, i_key[W]      cipher key load request and value
//   i_valid, i_block[W]       incoming state block
//   o_valid, o_block[W]       registered result block
//   o_round[4], o_last        round index of the applied key, final-round flag
//   o_key_ready, o_drop       key loaded, discarded-block pulse
// Modports: master drives i_*, slave (the stage) drives o_*.

interface addroundkey_sched_if #(
  parameter int W = 128
);
  logic         i_key_load;
  logic [W-1:0] i_key;
  logic         i_valid;
  logic [W-1:0] i_block;
  logic         o_valid;
  logic [W-1:0] o_block;
  logic [3:0]   o_round;
  logic         o_last;
  logic         o_key_ready;
  logic         o_drop;

  modport master (
    output i_key_load, i_key, i_valid, i_block,
    input  o_valid, o_block, o_round, o_last, o_key_ready, o_drop
  );

  modport slave (
    input  i_key_load, i_key, i_valid, i_block,
    output o_valid, o_block, o_round, o_last, o_key_ready, o_drop
  );
endinterface

// File: rtl/addroundkey_sched.sv
// rtl/addroundkey_sched.sv - AES-128 AddRoundKey with on-the-fly key schedule
//
// Purpose: XORs each accepted state block with the current round key,
//          registers the result, and steps the key schedule one round per
//          accepted block (rounds 0..NR, then back to the cipher key).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   addroundkey_sched_if.slave (key load, block in, result out)

module addroundkey_sched #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NR   = 10
) (
  input  logic                clk,
  input  logic                rst,
  addroundkey_sched_if.slave  bus
);

  localparam int         BW     = WORD * NB;
  localparam logic [3:0] LAST_R = 4'(NR);

  // Forward AES S-box.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [WORD-1:0] rot_word(input logic [WORD-1:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One Nk=4 expansion step: each new word chains off the previous new word.
  function automatic logic [BW-1:0] next_key(input logic [BW-1:0] k, input logic [7:0] rc);
    logic [WORD-1:0] w0, w1, w2, w3, t;
    logic [WORD-1:0] n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word(rot_word(w3)) ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  endfunction

  // Key-ready tracking: blocks are only accepted once a cipher key exists.
  typedef enum logic {
    ST_NOKEY = 1'b0,
    ST_KEYED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   ckey_q,  ckey_d;
  logic [BW-1:0]   key_q,   key_d;
  logic [3:0]      rnd_q,   rnd_d;
  logic [7:0]      rcon_q,  rcon_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   block_q, block_d;
  logic [3:0]      round_q, round_d;
  logic            drop_q,  drop_d;

  logic            key_ready;
  logic            accept;

  assign key_ready = (state_q == ST_KEYED);
  // A simultaneous key load takes priority over the block.
  assign accept    = bus.i_valid && key_ready && !bus.i_key_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_NOKEY;
      ckey_q  <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      block_q <= '0;
      round_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ckey_q  <= ckey_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      block_q <= block_d;
      round_q <= round_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ckey_d  = ckey_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    valid_d = 1'b0;
    block_d = block_q;
    round_d = round_q;
    drop_d  = bus.i_valid && (!key_ready || bus.i_key_load);

    if (bus.i_key_load) begin
      state_d = ST_KEYED;
      ckey_d  = bus.i_key;
      key_d   = bus.i_key;
      rnd_d   = 4'd0;
      rcon_d  = 8'h01;
    end else if (accept) begin
      valid_d = 1'b1;
      block_d = bus.i_block ^ key_q;
      round_d = rnd_q;
      if (rnd_q < LAST_R) begin
        key_d  = next_key(key_q, rcon_q);
        rnd_d  = rnd_q + 4'd1;
        rcon_d = xtime(rcon_q);
      end else begin
        // Past the final round the schedule restarts from the stored cipher key.
        key_d  = ckey_q;
        rnd_d  = 4'd0;
        rcon_d = 8'h01;
      end
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_block     = block_q;
  assign bus.o_round     = round_q;
  assign bus.o_last      = valid_q && (round_q == LAST_R);
  assign bus.o_key_ready = key_ready;
  assign bus.o_drop      = drop_q;

endmodule

// File: tb/tb_addroundkey_sched.sv
// tb/tb_addroundkey_sched.sv - directed self-checking bench for addroundkey_sched

module tb_addroundkey_sched;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  logic [127:0] rk [0:10];
  logic [127:0] key_a;
  logic [127:0] key_b;
  logic [127:0] key_b_r1;
  logic [127:0] last_blk;
  int           gaps [0:2];

  addroundkey_sched_if #(.W(128)) bus ();

  addroundkey_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic [127:0] blk, input logic [127:0] key);
    bus.i_valid    = v;
    bus.i_key_load = ld;
    bus.i_block    = blk;
    bus.i_key      = key;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [127:0] blk,
                         input logic [3:0] r, input logic last);
    chk({tag, ".valid"}, 128'(bus.o_valid), 128'(v));
    chk({tag, ".block"}, bus.o_block, blk);
    chk({tag, ".round"}, 128'(bus.o_round), 128'(r));
    chk({tag, ".last"},  128'(bus.o_last), 128'(last));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;

    key_a    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_b    = 128'h000102030405060708090a0b0c0d0e0f;
    key_b_r1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[0]  = key_a;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    gaps[0] = 0;
    gaps[1] = 1;
    gaps[2] = 3;

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    tick;
    tick;
    chk_out("reset", 1'b0, '0, 4'd0, 1'b0);
    chk("reset.key_ready", 128'(bus.o_key_ready), 128'd0);
    chk("reset.drop", 128'(bus.o_drop), 128'd0);
    rst = 1'b0;
    tick;

    // Block before any key load is dropped
    drive(1'b1, 1'b0, 128'h3243f6a8885a308d313198a2e0370734, '0);
    tick;
    chk("nokey.valid", 128'(bus.o_valid), 128'd0);
    chk("nokey.drop", 128'(bus.o_drop), 128'd1);
    drive(1'b0, 1'b0, '0, '0);
    tick;
    chk("nokey.drop_pulse", 128'(bus.o_drop), 128'd0);

    // FIPS-197 first AddRoundKey
    drive(1'b0, 1'b1, '0, key_a);
    tick;
    chk("load.key_ready", 128'(bus.o_key_ready), 128'd1);
    chk("load.valid", 128'(bus.o_valid), 128'd0);
    drive(1'b1, 1'b0, 128'h3243f6a8885a308d313198a2e0370734, '0);
    tick;
    chk_out("fips", 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0);

    // Full schedule back-to-back, then wrap
    drive(1'b0, 1'b1, '0, key_a);
    tick;
    for (int r = 0; r <= 10; r++) begin
      drive(1'b1, 1'b0, '0, '0);
      tick;
      chk_out($sformatf("b2b.r%0d", r), 1'b1, rk[r], 4'(r), (r == 10));
    end
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("b2b.wrap", 1'b1, key_a, 4'd0, 1'b0);

    // Same schedule with 0/1/3 idle cycles between blocks
    drive(1'b0, 1'b1, '0, key_a);
    tick;
    for (int r = 0; r <= 10; r++) begin
      drive(1'b1, 1'b0, '0, '0);
      tick;
      chk_out($sformatf("gap.r%0d", r), 1'b1, rk[r], 4'(r), (r == 10));
      last_blk = rk[r];
      drive(1'b0, 1'b0, '0, '0);
      for (int g = 0; g < gaps[r % 3]; g++) begin
        tick;
        chk($sformatf("gap.idle_valid.r%0d", r), 128'(bus.o_valid), 128'd0);
        chk($sformatf("gap.hold.r%0d", r), bus.o_block, last_blk);
      end
    end

    // Block together with a key load: load wins, block dropped
    drive(1'b1, 1'b0, '0, '0);
    tick;
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("pre_collide", 1'b1, rk[1], 4'd1, 1'b0);
    drive(1'b1, 1'b1, 128'hffffffffffffffffffffffffffffffff, key_a);
    tick;
    chk("collide.valid", 128'(bus.o_valid), 128'd0);
    chk("collide.drop", 128'(bus.o_drop), 128'd1);
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("collide.next", 1'b1, key_a, 4'd0, 1'b0);
    chk("collide.drop_clear", 128'(bus.o_drop), 128'd0);

    // Reload a different key at rnd=5
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 1'b0, '0, '0);
      tick;
    end
    chk_out("pre_reload", 1'b1, rk[4], 4'd4, 1'b0);
    drive(1'b0, 1'b1, '0, key_b);
    tick;
    chk("reload.valid", 128'(bus.o_valid), 128'd0);
    chk("reload.hold", bus.o_block, rk[4]);
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("reload.r0", 1'b1, key_b, 4'd0, 1'b0);
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("reload.r1", 1'b1, key_b_r1, 4'd1, 1'b0);

    // Asynchronous reset between edges
    drive(1'b0, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, '0, 4'd0, 1'b0);
    chk("async_rst.key_ready", 128'(bus.o_key_ready), 128'd0);
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk("post_rst.valid", 128'(bus.o_valid), 128'd0);
    chk("post_rst.drop", 128'(bus.o_drop), 128'd1);
    chk("post_rst.key_ready", 128'(bus.o_key_ready), 128'd0);
    drive(1'b0, 1'b1, '0, key_a);
    tick;
    drive(1'b1, 1'b0, '0, '0);
    tick;
    chk_out("post_rst.r0", 1'b1, key_a, 4'd0, 1'b0);
    drive(1'b0, 1'b0, '0, '0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
